// File: rtl/perf_defs_pkg.sv
// Shared definitions for the performance-counter UART reporter:
// frame geometry, FSM state encodings and a baud-counter width helper.
package perf_defs;

   localparam int NUM_WORDS           = 6;
   localparam int BYTES_PER_WORD      = 4;
   localparam int DATA_BYTES          = NUM_WORDS * BYTES_PER_WORD;
   localparam int FRAME_BYTES         = 26;
   localparam int BITS_PER_FRAME_BYTE = 10;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SYNC = 3'd1,
      ST_DATA = 3'd2,
      ST_CSUM = 3'd3,
      ST_FIN  = 3'd4
   } state_t;

   // Width of a counter that runs 0..cpb-1; never narrower than one bit.
   function automatic int baud_width(input int cpb);
      return (cpb > 1) ? $clog2(cpb) : 1;
   endfunction

endpackage

// File: rtl/perf_uart_reporter_uart_tx_byte.sv
// Single-byte 8N1 UART transmitter. Holds each bit for CLKS_PER_BIT cycles
// and reports ready during the last cycle of the stop bit so the caller can
// load the next byte with no idle gap.
module uart_tx_byte
   import perf_defs::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] data,
   output logic       tx,
   output logic       ready
);

   localparam int                BAUD_W    = baud_width(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]        STOP_IDX  = 4'(BITS_PER_FRAME_BYTE - 1);

   logic              active_reg;
   logic              tx_reg;
   logic [7:0]        shift_reg;
   logic [3:0]        bit_cnt_reg;
   logic [BAUD_W-1:0] baud_reg;
   logic              baud_last;
   logic              stop_end;

   assign baud_last = (baud_reg == BAUD_LAST);
   // Last cycle of the stop bit: the next byte may start on the coming edge.
   assign stop_end  = active_reg && (bit_cnt_reg == STOP_IDX) && baud_last;
   assign ready     = !active_reg || stop_end;
   assign tx        = tx_reg;

   // Bit timing and serialisation: start bit, 8 data bits LSB first, stop bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         active_reg  <= 1'b0;
         tx_reg      <= 1'b1;
         shift_reg   <= 8'h00;
         bit_cnt_reg <= 4'd0;
         baud_reg    <= '0;
      end else if (load && ready) begin
         active_reg  <= 1'b1;
         tx_reg      <= 1'b0;
         shift_reg   <= data;
         bit_cnt_reg <= 4'd0;
         baud_reg    <= '0;
      end else if (active_reg) begin
         if (baud_last) begin
            baud_reg <= '0;
            if (bit_cnt_reg == STOP_IDX) begin
               active_reg <= 1'b0;
               tx_reg     <= 1'b1;
            end else begin
               bit_cnt_reg <= bit_cnt_reg + 4'd1;
               if (bit_cnt_reg == STOP_IDX - 4'd1) begin
                  tx_reg <= 1'b1;
               end else begin
                  tx_reg    <= shift_reg[0];
                  shift_reg <= {1'b0, shift_reg[7:1]};
               end
            end
         end else begin
            baud_reg <= baud_reg + BAUD_W'(1);
         end
      end
   end

endmodule

// File: rtl/perf_uart_reporter.sv
// Snapshots six 32-bit performance counters on request and streams them out
// as a 26-byte UART frame: sync byte, 24 little-endian data bytes, XOR checksum.
module perf_uart_reporter
   import perf_defs::*;
#(
   parameter int         CLKS_PER_BIT = 868,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] cycle_count,
   input  logic [31:0] instr_count,
   input  logic [31:0] mem_read_count,
   input  logic [31:0] mem_write_count,
   input  logic [31:0] rf_read_count,
   input  logic [31:0] rf_write_count,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   // Frame byte index of the last data byte (sync byte is index 0).
   localparam logic [4:0] LAST_DATA_IDX = 5'(FRAME_BYTES - 2);

   state_t      state_reg;
   logic        busy_reg;
   logic        done_reg;
   logic [4:0]  byte_idx_reg;
   logic [7:0]  csum_reg;
   logic [31:0] snap_reg   [NUM_WORDS];
   logic [31:0] counters   [NUM_WORDS];
   logic [7:0]  snap_bytes [DATA_BYTES];

   logic        load;
   logic [7:0]  load_data;
   logic        tx_ready;

   assign counters[0] = cycle_count;
   assign counters[1] = instr_count;
   assign counters[2] = mem_read_count;
   assign counters[3] = mem_write_count;
   assign counters[4] = rf_read_count;
   assign counters[5] = rf_write_count;

   // Flatten the snapshot into transmit order: word by word, LSB byte first.
   for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_snap_bytes
      assign snap_bytes[gi] = snap_reg[gi / BYTES_PER_WORD][(gi % BYTES_PER_WORD) * 8 +: 8];
   end

   assign busy = busy_reg;
   assign done = done_reg;

   // Choose the next byte for the transmitter. In SYNC/DATA the current frame
   // index equals the data index of the following byte.
   always_comb begin
      load      = 1'b0;
      load_data = SYNC_BYTE;
      case (state_reg)
         ST_IDLE, ST_FIN: begin
            load      = start;
            load_data = SYNC_BYTE;
         end
         ST_SYNC, ST_DATA: begin
            load = tx_ready;
            if (byte_idx_reg == LAST_DATA_IDX) begin
               load_data = csum_reg;
            end else begin
               load_data = snap_bytes[byte_idx_reg];
            end
         end
         default: begin
            load      = 1'b0;
            load_data = SYNC_BYTE;
         end
      endcase
   end

   // Frame sequencer: snapshot, byte sequencing, running checksum, busy/done.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         byte_idx_reg <= 5'd0;
         csum_reg     <= 8'h00;
         for (int w = 0; w < NUM_WORDS; w++) begin
            snap_reg[w] <= 32'h0;
         end
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE, ST_FIN: begin
               if (start) begin
                  for (int w = 0; w < NUM_WORDS; w++) begin
                     snap_reg[w] <= counters[w];
                  end
                  csum_reg     <= 8'h00;
                  byte_idx_reg <= 5'd0;
                  busy_reg     <= 1'b1;
                  state_reg    <= ST_SYNC;
               end else begin
                  state_reg <= ST_IDLE;
               end
            end
            ST_SYNC: begin
               if (tx_ready) begin
                  csum_reg     <= csum_reg ^ load_data;
                  byte_idx_reg <= byte_idx_reg + 5'd1;
                  state_reg    <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (tx_ready) begin
                  byte_idx_reg <= byte_idx_reg + 5'd1;
                  if (byte_idx_reg == LAST_DATA_IDX) begin
                     state_reg <= ST_CSUM;
                  end else begin
                     csum_reg <= csum_reg ^ load_data;
                  end
               end
            end
            ST_CSUM: begin
               if (tx_ready) begin
                  state_reg    <= ST_FIN;
                  busy_reg     <= 1'b0;
                  done_reg     <= 1'b1;
                  byte_idx_reg <= 5'd0;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .data  (load_data),
      .tx    (tx),
      .ready (tx_ready)
   );

endmodule

// File: tb/tb_perf_uart_reporter.sv
// Bench for perf_uart_reporter with 4 clocks per bit: table of counter sets
// with hand-computed checksums, a byte scoreboard fed at start and drained by
// a bit-centre UART decoder, plus reset/start corner sequences.
module tb_perf_uart_reporter;

   localparam int CPB       = 4;
   localparam int BYTE_CYC  = 10 * CPB;
   localparam int FRAME_CYC = 260 * CPB;
   localparam int NVEC      = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] cycle_count = '0;
   logic [31:0] instr_count = '0;
   logic [31:0] mem_read_count = '0;
   logic [31:0] mem_write_count = '0;
   logic [31:0] rf_read_count = '0;
   logic [31:0] rf_write_count = '0;
   logic        tx;
   logic        busy;
   logic        done;

   typedef struct {
      logic [5:0][31:0] cnt;
      bit               inc;
      int               busy_pulse;
      bit               chain;
      logic [7:0]       csum;
   } vec_t;

   vec_t       tv [NVEC];
   logic [7:0] exp_q [$];
   int         checks = 0;
   int         errors = 0;
   int         frame_cyc = 0;
   int         busy_start_at = -1;
   bit         inc_en = 1'b0;
   int         done_seen = 0;

   always #5 clk = ~clk;

   perf_uart_reporter #(
      .CLKS_PER_BIT (CPB),
      .SYNC_BYTE    (8'hA5)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .cycle_count     (cycle_count),
      .instr_count     (instr_count),
      .mem_read_count  (mem_read_count),
      .mem_write_count (mem_write_count),
      .rf_read_count   (rf_read_count),
      .rf_write_count  (rf_write_count),
      .tx              (tx),
      .busy            (busy),
      .done            (done)
   );

   function automatic vec_t mk(input logic [31:0] c0, c1, c2, c3, c4, c5,
                               input bit inc, input int bp, input bit ch,
                               input logic [7:0] cs);
      vec_t v;
      v.cnt[0] = c0; v.cnt[1] = c1; v.cnt[2] = c2;
      v.cnt[3] = c3; v.cnt[4] = c4; v.cnt[5] = c5;
      v.inc = inc; v.busy_pulse = bp; v.chain = ch; v.csum = cs;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic set_counters(input logic [5:0][31:0] c);
      cycle_count     = c[0];
      instr_count     = c[1];
      mem_read_count  = c[2];
      mem_write_count = c[3];
      rf_read_count   = c[4];
      rf_write_count  = c[5];
   endtask

   // Advance to the next falling edge and apply per-cycle stimulus.
   task automatic tick();
      @(negedge clk);
      frame_cyc++;
      start = 1'b0;
      if (frame_cyc == busy_start_at) start = 1'b1;
      if (inc_en) cycle_count = cycle_count + 32'd1;
      if (done) done_seen++;
   endtask

   // Called at a falling edge: drive start, push the expected frame.
   task automatic start_frame(input int i);
      set_counters(tv[i].cnt);
      exp_q.push_back(8'hA5);
      for (int w = 0; w < 6; w++)
         for (int k = 0; k < 4; k++)
            exp_q.push_back(tv[i].cnt[w][8*k +: 8]);
      exp_q.push_back(tv[i].csum);
      inc_en        = tv[i].inc;
      busy_start_at = tv[i].busy_pulse;
      start         = 1'b1;
      frame_cyc     = -1;
      tick();
      done_seen = 0;
      if (!inc_en) set_counters(~tv[i].cnt);
      check($sformatf("start_bit_latency_%0d", i), tx, 1'b0);
      check($sformatf("busy_rise_%0d", i), busy, 1'b1);
   endtask

   // Decode 26 bytes at bit centres, then check the done/busy timing.
   task automatic run_frame(input int i);
      logic [9:0] obs;
      logic [7:0] e;
      for (int b = 0; b < 26; b++) begin
         obs = '0;
         for (int j = 0; j < 10; j++) begin
            while (frame_cyc < b * BYTE_CYC + j * CPB + CPB / 2) tick();
            obs[j] = tx;
         end
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty frame=%0d byte=%0d actual=%0h required=none", i, b, obs);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("frame%0d_byte%0d", i, b), obs, {1'b1, e, 1'b0});
         end
         if (b == 0) check($sformatf("sync_bits_%0d", i), obs, 10'h34A);
      end
      while (frame_cyc < FRAME_CYC - 1) tick();
      check($sformatf("busy_last_bit_%0d", i), busy, 1'b1);
      check($sformatf("done_early_%0d", i), done, 1'b0);
      tick();
      check($sformatf("done_pulse_%0d", i), done, 1'b1);
      check($sformatf("busy_fin_%0d", i), busy, 1'b0);
      check($sformatf("tx_fin_%0d", i), tx, 1'b1);
      check($sformatf("done_count_%0d", i), done_seen, 1);
      $display("frame %0d complete at cycle %0d csum %02h", i, frame_cyc, tv[i].csum);
      inc_en        = 1'b0;
      busy_start_at = -1;
      if (tv[i].chain) begin
         start_frame(i + 1);
      end else begin
         tick();
         check($sformatf("done_one_cycle_%0d", i), done, 1'b0);
         check($sformatf("tx_idle_%0d", i), tx, 1'b1);
         check($sformatf("done_total_%0d", i), done_seen, 1);
      end
   endtask

   initial begin
      int low_cnt;
      tv[0] = mk(32'h12345678, 0, 0, 0, 0, 0, 1'b0, -1, 1'b0, 8'h08);
      tv[1] = mk(0, 0, 0, 0, 0, 0, 1'b0, -1, 1'b0, 8'h00);
      tv[2] = mk('1, '1, '1, '1, '1, '1, 1'b0, -1, 1'b0, 8'h00);
      tv[3] = mk(1, 2, 3, 4, 5, 6, 1'b0, -1, 1'b0, 8'h07);
      tv[4] = mk(25, 0, 0, 0, 0, 0, 1'b1, -1, 1'b0, 8'h19);
      tv[5] = mk(0, 32'h0F000000, 0, 0, 0, 32'h000000FF, 1'b0, 500, 1'b0, 8'hF0);
      tv[6] = mk(0, 0, 32'hCAFEBABE, 0, 0, 0, 1'b0, -1, 1'b1, 8'h30);
      tv[7] = mk(0, 0, 0, 0, 32'h01020304, 0, 1'b0, -1, 1'b0, 8'h04);

      // Reset state.
      reset = 1'b1;
      repeat (3) tick();
      check("reset_tx", tx, 1'b1);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      reset = 1'b0;
      tick();
      tick();

      // Reset and start on the same edge: reset wins, nothing is queued.
      reset = 1'b1;
      start = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_start_busy", busy, 1'b0);
      check("rst_start_tx", tx, 1'b1);
      tick();
      tick();
      check("no_queued_start", busy, 1'b0);

      // Table-driven frames.
      for (int i = 0; i < NVEC; i++) begin
         if (i == 0 || !tv[i-1].chain) begin
            tick();
            tick();
            start_frame(i);
         end
         run_frame(i);
      end

      // Reset in the middle of a frame, then a clean frame.
      tick();
      start_frame(3);
      while (frame_cyc < 300) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_tx", tx, 1'b1);
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      exp_q.delete();
      done_seen = 0;
      low_cnt   = 0;
      repeat (1100) begin
         tick();
         if (tx !== 1'b1) low_cnt++;
      end
      check("midrst_no_done", done_seen, 0);
      check("midrst_tx_idle_cycles_low", low_cnt, 0);
      start_frame(0);
      run_frame(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/perf_uart_reporter.md
PERF_UART_REPORTER -- requirements
Module: perf_uart_reporter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, giving clock cycles per UART bit (100 MHz / 115200 baud).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, giving the frame header byte.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to snapshot and transmit the counters.
REQ-006 SHALL have ports cycle_count, instr_count, mem_read_count, mem_write_count, rf_read_count, rf_write_count  input  32 each  live CPU performance counters.
REQ-007 SHALL have port tx  output  1  UART serial line, 8N1, idle high.
REQ-008 SHALL have port busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when a frame completes.

Function
REQ-010 SHALL capture all six counters into internal snapshot registers on the edge where start=1 and the FSM is IDLE; later counter changes SHALL NOT affect the frame.
REQ-011 SHALL ignore start while busy=1, with no re-snapshot and no queued request.
REQ-012 SHALL transmit each frame as 26 bytes: SYNC_BYTE; then 24 data bytes, the counters in REQ-006 order, each little-endian; then a checksum byte equal to the XOR of the 24 data bytes.
REQ-013 SHALL serialize each byte as a start bit (0), 8 data bits LSB first, and a stop bit (1); each bit SHALL be held for exactly CLKS_PER_BIT cycles.
REQ-014 SHALL send bytes back to back with no idle gap between one stop bit and the next start bit.
REQ-015 SHALL use FSM states IDLE -> SYNC -> DATA -> CSUM -> FIN -> IDLE.
REQ-016 SHALL move from IDLE to SYNC on an accepted start.
REQ-017 SHALL move from SYNC to DATA after the sync byte's stop bit.
REQ-018 SHALL stay in DATA until byte index 23 completes, then move to CSUM.
REQ-019 SHALL move from CSUM to FIN after the checksum byte's stop bit.
REQ-020 SHALL return from FIN to IDLE after exactly one cycle.
REQ-021 SHALL raise busy and drive tx=0 (start bit) in the cycle after the edge that accepts start, i.e. registered with zero additional latency.
REQ-022 SHALL make the frame length exactly 260*CLKS_PER_BIT cycles, measured from the first tx=0 to the end of the final stop bit.
REQ-023 SHALL assert done for exactly one cycle, in FIN, in the cycle after the final stop bit ends; busy SHALL be 0 in that same cycle.
REQ-024 SHALL accept a new start in the FIN cycle or any later cycle.
REQ-025 SHALL accumulate the checksum incrementally as each data byte is loaded; the checksum SHALL be cleared on accepted start.
REQ-026 SHALL use a baud counter of ceil(log2(CLKS_PER_BIT)) bits that wraps to 0 at CLKS_PER_BIT-1, and a 5-bit byte index (0..25).

Reset
REQ-027 SHALL, when reset=1 at a clock edge, set FSM=IDLE, tx=1, busy=0, done=0, and clear the baud counter, bit counter, byte index, checksum and snapshots.
REQ-028 SHALL abort any frame in progress on reset mid-frame, with tx returning high after that edge and no done pulse.
REQ-029 SHALL give reset priority over start when both are asserted on the same edge.

Structure
REQ-030 SHALL take NUM_WORDS=6, FRAME_BYTES=26, BITS_PER_FRAME_BYTE=10 and the FSM state encodings from the shared package perf_defs.
REQ-031 SHALL instantiate one sub-module, uart_tx_byte (inputs clk, reset, load, data[7:0]; outputs tx, ready), which handles per-byte framing and bit timing; the top level owns frame sequencing, snapshot and checksum.
REQ-032 SHALL let uart_tx_byte accept load only when ready=1, and SHALL have it raise ready in the cycle its stop bit ends, so that back-to-back bytes per REQ-014 are possible.

Verification (CLKS_PER_BIT=4)
REQ-033 SHALL verify the sync byte: after start, tx samples taken at bit centres SHALL read 0,1,0,1,0,0,1,0,1,1 for the first 10 bits (0xA5).
REQ-034 SHALL verify the full frame: with cycle_count=32'h12345678 and all other counters 0, the decoded bytes SHALL be A5 78 56 34 12 followed by 20×00 and checksum 08, and done SHALL pulse at cycle 1040 after the first start bit.
REQ-035 SHALL verify the snapshot: with cycle_count=25 at start, then incremented every cycle during the frame, the decoded cycle_count SHALL equal 25.
REQ-036 SHALL verify start-while-busy: a start pulse at cycle 500 of the frame SHALL leave the frame unchanged, with exactly one done pulse and tx high after it.
REQ-037 SHALL verify reset mid-frame: reset at cycle 300 SHALL drive tx=1, busy=0 and give no done pulse; a following start SHALL produce a complete, correct 26-byte frame.
REQ-038 SHALL verify back-to-back frames: start asserted in the done cycle SHALL begin a second frame on the next cycle with no idle-high gap beyond the FIN cycle.
